// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: management DR command/status layout, op codes and
// the instruction code the TAP decoder uses to select the management DR.
package jtag_pkg;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_READ    = 2'b01,
        OP_WRITE   = 2'b10,
        OP_NOP_ALT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        READ_WAIT
    } bridge_state_e;

    // Field offsets within the management DR (default 20-bit address, 32-bit data)
    localparam int unsigned OP_LSB    = 0;
    localparam int unsigned BS_LSB    = 2;
    localparam int unsigned ADDR_LSB  = 6;
    localparam int unsigned WDATA_LSB = 26;
    localparam int unsigned SR_WIDTH  = 58;

    localparam int unsigned ST_BUSY      = 0;
    localparam int unsigned ST_OVERFLOW  = 1;
    localparam int unsigned ST_TIMEOUT   = 2;
    localparam int unsigned ST_LAST_READ = 3;

    localparam logic [4:0] MGMT_DR_INSTR = 5'b01000;

    function automatic logic isBusOp(input logic [1:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/jtag_management_bridge_if.sv
// Management bus between the JTAG bridge (master) and the register fabric (slave).
interface jtag_management_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  writeEnable;
    logic                  readEnable;
    logic [3:0]            byteSelect;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] writeData;
    logic [DATA_WIDTH-1:0] readData;
    logic                  busy;

    modport master (
        output writeEnable, readEnable, byteSelect, address, writeData,
        input  readData, busy
    );

    modport slave (
        input  writeEnable, readEnable, byteSelect, address, writeData,
        output readData, busy
    );
endinterface

// File: rtl/jtag_shift_register.sv
// Generic TAP data register: parallel load on capture, LSB-first serial shift.
module jtag_shift_register #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             serIn,
    input  logic [WIDTH-1:0] parIn,
    output logic [WIDTH-1:0] parOut,
    output logic             serOut
);
    logic [WIDTH-1:0] q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= parIn;
        end else if (shift) begin
            q <= {serIn, q[WIDTH-1:1]};
        end
    end

    assign parOut = q;
    assign serOut = q[0];
endmodule

// File: rtl/jtag_management_bridge.sv
// Management DR bridge: a scanned-in command runs one management-bus transaction
// in the clk domain; the result and sticky status come back on the next capture.
module jtag_management_bridge
    import jtag_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 20,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic tap_select,
    input  logic tap_capture,
    input  logic tap_shift,
    input  logic tap_update,
    input  logic tap_reset,
    input  logic tap_tdi,
    output logic tap_tdo,
    output logic busy,
    jtag_management_bridge_if.master management
);
    localparam int unsigned WD_LSB = ADDR_LSB + ADDR_WIDTH;
    localparam int unsigned SRW    = WD_LSB + DATA_WIDTH;
    localparam int unsigned CW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [SRW-1:0]        srQ;
    logic [SRW-1:0]        srCapture;
    logic [1:0]            srOp;
    logic                  doCapture;
    logic                  doShift;
    logic                  cmdValid;

    bridge_state_e         state;
    bridge_state_e         nextState;
    logic                  latchCmd;
    logic                  accept;
    logic                  abort;

    logic                  isRead;
    logic [ADDR_WIDTH-1:0] addrQ;
    logic [3:0]            bsQ;
    logic [DATA_WIDTH-1:0] wdQ;
    logic [DATA_WIDTH-1:0] rdQ;
    logic [CW-1:0]         stallCnt;
    logic                  overflow;
    logic                  timeoutFlag;
    logic                  lastWasRead;

    assign doCapture = tap_select & tap_capture;
    assign doShift   = tap_select & tap_shift & ~tap_capture;
    assign srOp      = srQ[OP_LSB +: 2];
    assign cmdValid  = tap_select & tap_update & isBusOp(srOp);

    always_comb begin
        srCapture                        = '0;
        srCapture[ST_BUSY]               = busy;
        srCapture[ST_OVERFLOW]           = overflow;
        srCapture[ST_TIMEOUT]            = timeoutFlag;
        srCapture[ST_LAST_READ]          = lastWasRead;
        srCapture[ADDR_LSB +: ADDR_WIDTH] = addrQ;
        srCapture[WD_LSB +: DATA_WIDTH]   = rdQ;
    end

    jtag_shift_register #(.WIDTH(SRW)) u_sr (
        .clk    (clk),
        .rst    (rst),
        .load   (doCapture),
        .shift  (doShift),
        .serIn  (tap_tdi),
        .parIn  (srCapture),
        .parOut (srQ),
        .serOut (tap_tdo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        latchCmd  = 1'b0;
        accept    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (cmdValid) begin
                    latchCmd  = 1'b1;
                    nextState = ISSUE;
                end
            end
            ISSUE: begin
                if (!management.busy) begin
                    accept    = 1'b1;
                    nextState = isRead ? READ_WAIT : IDLE;
                end else if (stallCnt == CNT_LAST) begin
                    abort     = 1'b1;
                    nextState = IDLE;
                end
            end
            READ_WAIT: nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            isRead      <= 1'b0;
            addrQ       <= '0;
            bsQ         <= '1;
            wdQ         <= '0;
            rdQ         <= '0;
            stallCnt    <= '0;
            lastWasRead <= 1'b0;
            overflow    <= 1'b0;
            timeoutFlag <= 1'b0;
        end else begin
            if (latchCmd) begin
                isRead   <= (srOp == OP_READ);
                bsQ      <= srQ[BS_LSB +: 4];
                addrQ    <= srQ[ADDR_LSB +: ADDR_WIDTH];
                wdQ      <= srQ[WD_LSB +: DATA_WIDTH];
                stallCnt <= '0;
            end else if (state == ISSUE && management.busy) begin
                stallCnt <= stallCnt + CW'(1);
            end
            if (state == READ_WAIT) begin
                rdQ         <= management.readData;
                lastWasRead <= 1'b1;
            end else if (accept && !isRead) begin
                lastWasRead <= 1'b0;
            end
            // Clear-on-capture and tap_reset lose to a set in the same cycle
            overflow    <= (overflow & ~(doCapture | tap_reset)) | (cmdValid & (state != IDLE));
            timeoutFlag <= (timeoutFlag & ~(doCapture | tap_reset)) | abort;
        end
    end

    assign busy                   = (state != IDLE);
    assign management.writeEnable = (state == ISSUE) & ~isRead;
    assign management.readEnable  = (state == ISSUE) & isRead;
    assign management.byteSelect  = bsQ;
    assign management.address     = addrQ;
    assign management.writeData   = wdQ;
endmodule

// File: tb/tb_jtag_management_bridge.sv
// Bench for jtag_management_bridge: transaction-level model checked every cycle,
// plus directed scans with literal expectations.
module tb_jtag_management_bridge;
    localparam int unsigned AW  = 20;
    localparam int unsigned DW  = 32;
    localparam int unsigned TO  = 4;
    localparam int unsigned SRW = 58;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic cap = 1'b0;
    logic shf = 1'b0;
    logic upd = 1'b0;
    logic trst = 1'b0;
    logic tdi = 1'b0;
    logic tdo;
    logic dutBusy;

    always #5 clk = ~clk;

    jtag_management_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mgmt ();

    jtag_management_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tap_select  (sel),
        .tap_capture (cap),
        .tap_shift   (shf),
        .tap_update  (upd),
        .tap_reset   (trst),
        .tap_tdi     (tdi),
        .tap_tdo     (tdo),
        .busy        (dutBusy),
        .management  (mgmt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: a pending bus request, a pending read sample, sticky flags
    bit              mValid = 1'b0;
    bit              mIssuing, mReadPend, mIsRead, mLastRead, mOvf, mTo;
    logic [AW-1:0]   mAddr;
    logic [3:0]      mBs;
    logic [DW-1:0]   mWd, mRd;
    int              mWait;
    logic [SRW-1:0]  mSR;
    logic [SRW-1:0]  status;
    logic [1:0]      op;
    bit              updOk, ovfSet, toSet, clr;
    int              wrCnt = 0;
    int              rdCnt = 0;

    always @(negedge clk) begin
        if (mValid) begin
            check("writeEnable", mgmt.writeEnable, mIssuing && !mIsRead);
            check("readEnable",  mgmt.readEnable,  mIssuing && mIsRead);
            check("busy",        dutBusy,          mIssuing || mReadPend);
            check("tdo",         tdo,              mSR[0]);
            check("address",     mgmt.address,     mAddr);
            check("byteSelect",  mgmt.byteSelect,  mBs);
            check("writeData",   mgmt.writeData,   mWd);
            if (mgmt.writeEnable === 1'b1) wrCnt++;
            if (mgmt.readEnable === 1'b1) rdCnt++;
        end
        if (rst) begin
            mIssuing = 0; mReadPend = 0; mIsRead = 0; mLastRead = 0; mOvf = 0; mTo = 0;
            mAddr = '0; mBs = 4'hF; mWd = '0; mRd = '0; mWait = 0; mSR = '0;
            mValid = 1'b1;
        end else if (mValid) begin
            status = {mRd, mAddr, 2'b00, mLastRead, mTo, mOvf, mIssuing || mReadPend};
            op     = mSR[1:0];
            updOk  = sel && upd && (op == 2'b01 || op == 2'b10);
            ovfSet = updOk && (mIssuing || mReadPend);
            toSet  = 0;
            if (mIssuing) begin
                if (mgmt.busy) begin
                    mWait++;
                    if (mWait == TO) begin
                        mIssuing = 0;
                        toSet    = 1;
                    end
                end else begin
                    mIssuing = 0;
                    if (mIsRead) mReadPend = 1;
                    else         mLastRead = 0;
                end
            end else if (mReadPend) begin
                mRd       = mgmt.readData;
                mLastRead = 1;
                mReadPend = 0;
            end else if (updOk) begin
                mIssuing = 1;
                mIsRead  = (op == 2'b01);
                mBs      = mSR[5:2];
                mAddr    = mSR[25:6];
                mWd      = mSR[57:26];
                mWait    = 0;
            end
            if (sel && cap)      mSR = status;
            else if (sel && shf) mSR = {tdi, mSR[SRW-1:1]};
            clr  = (sel && cap) || trst;
            mOvf = (mOvf && !clr) || ovfSet;
            mTo  = (mTo && !clr) || toSet;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SRW-1:0] cmd(input logic [1:0] o, input logic [3:0] bs,
                                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {d, a, bs, o};
    endfunction

    task automatic scan(input logic [SRW-1:0] din, input bit doUpd, output logic [SRW-1:0] dout);
        cap = 1'b1;
        tick();
        cap = 1'b0;
        for (int i = 0; i < SRW; i++) begin
            dout[i] = tdo;
            tdi     = din[i];
            shf     = 1'b1;
            tick();
        end
        shf = 1'b0;
        tdi = 1'b0;
        if (doUpd) begin
            upd = 1'b1;
            tick();
            upd = 1'b0;
        end
    endtask

    logic [SRW-1:0] o;
    int base;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mgmt.readData = '0;
        mgmt.busy     = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        sel = 1'b1;
        check("rstTdo",  tdo, 1'b0);
        check("rstBs",   mgmt.byteSelect, 4'hF);
        check("rstBusy", dutBusy, 1'b0);

        // Write, no stall
        base = wrCnt;
        scan(cmd(2'b10, 4'hF, 20'h00010, 32'hDEADBEEF), 1, o);
        check("wrEnOneClkAfterUpd", mgmt.writeEnable, 1'b1);
        check("wrAddr", mgmt.address, 20'h00010);
        check("wrData", mgmt.writeData, 32'hDEADBEEF);
        repeat (4) tick();
        check("wrPulses", wrCnt - base, 1);
        check("wrBusyAfter", dutBusy, 1'b0);

        // Read stalled three cycles
        mgmt.readData = 32'h12345678;
        scan(cmd(2'b01, 4'hF, 20'h00020, 32'h0), 0, o);
        base = rdCnt;
        mgmt.busy = 1'b1;
        upd = 1'b1; tick(); upd = 1'b0;
        repeat (3) tick();
        mgmt.busy = 1'b0;
        repeat (3) tick();
        check("rdPulses", rdCnt - base, 4);
        scan('0, 0, o);
        check("rdData",   o[57:26], 32'h12345678);
        check("rdAddr",   o[25:6], 20'h00020);
        check("rdStatus", o[5:0], 6'b001000);

        // Timeout with busy stuck
        scan(cmd(2'b01, 4'hF, 20'h00030, 32'h0), 0, o);
        base = rdCnt;
        mgmt.busy = 1'b1;
        upd = 1'b1; tick(); upd = 1'b0;
        repeat (8) tick();
        check("toPulses", rdCnt - base, 4);
        check("toBusy", dutBusy, 1'b0);
        mgmt.busy = 1'b0;
        scan('0, 0, o);
        check("toFlagSet",  o[2], 1'b1);
        check("toDataKept", o[57:26], 32'h12345678);
        scan('0, 0, o);
        check("toFlagCleared", o[2], 1'b0);

        // Overflow while a read is stalled
        mgmt.readData = 32'hCAFEF00D;
        scan(cmd(2'b01, 4'h3, 20'h00040, 32'h0), 0, o);
        base = rdCnt;
        mgmt.busy = 1'b1;
        upd = 1'b1; tick(); upd = 1'b0;
        tick();
        upd = 1'b1; tick(); upd = 1'b0;
        tick();
        mgmt.busy = 1'b0;
        repeat (3) tick();
        check("ovfPulses", rdCnt - base, 4);
        scan('0, 0, o);
        check("ovfFlagSet", o[1], 1'b1);
        check("ovfReadData", o[57:26], 32'hCAFEF00D);
        check("ovfNoTimeout", o[2], 1'b0);
        scan('0, 0, o);
        check("ovfFlagCleared", o[1], 1'b0);

        // Gating and nop
        base = wrCnt;
        scan(cmd(2'b10, 4'hF, 20'h00050, 32'h11111111), 0, o);
        sel = 1'b0;
        upd = 1'b1; tick(); upd = 1'b0;
        repeat (3) tick();
        sel = 1'b1;
        check("gatedNoWrite", wrCnt - base, 0);
        scan(cmd(2'b11, 4'hF, 20'h00060, 32'h22222222), 1, o);
        repeat (3) tick();
        check("nopNoWrite", wrCnt - base, 0);
        scan('0, 0, o);
        check("nopStatus", o[5:0], 6'b001000);

        // tap_reset clears a pending overflow
        scan(cmd(2'b01, 4'hF, 20'h00070, 32'h0), 0, o);
        mgmt.busy = 1'b1;
        upd = 1'b1; tick(); upd = 1'b0;
        tick();
        upd = 1'b1; tick(); upd = 1'b0;
        trst = 1'b1; tick(); trst = 1'b0;
        mgmt.busy = 1'b0;
        repeat (3) tick();
        scan('0, 0, o);
        check("tapRstOvf", o[1], 1'b0);
        check("tapRstLastRead", o[3], 1'b1);

        // Reset in the middle of an issued read
        scan(cmd(2'b01, 4'h5, 20'h00080, 32'h0), 0, o);
        mgmt.busy = 1'b1;
        upd = 1'b1; tick(); upd = 1'b0;
        tick();
        check("midRdEn", mgmt.readEnable, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rstRdEn", mgmt.readEnable, 1'b0);
        check("rstBusyMid", dutBusy, 1'b0);
        check("rstAddrMid", mgmt.address, 20'h0);
        check("rstBsMid", mgmt.byteSelect, 4'hF);
        mgmt.busy = 1'b0;
        scan('0, 0, o);
        check("rstCaptureZero", o, 58'h0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
